// File: rtl/slave_fifo_mc.sv
// Multi-channel slave FIFO flag and occupancy model.
// Tracks per-channel word and committed-buffer counts for a host-side drain,
// and presents full/partial flags for whichever channel is currently addressed.
// Write data is not stored; only the occupancy it implies is modelled.
module slave_fifo_mc #(
    parameter int unsigned U3_DATWD    = 32,
    parameter int unsigned CH_NUM      = 4,
    parameter int unsigned BUF_DPTH_WD = 13,
    parameter int unsigned BUF_DPTH    = 4096,
    parameter int unsigned BUFFER_NUM  = 8,
    parameter int unsigned WMARK       = 6,
    parameter int unsigned FLAG_DLY    = 3,
    parameter int unsigned DRAIN_CYC   = 16
) (
    input  logic                i_usb_pclk,
    input  logic                reset_n,
    input  logic                i_usb_cs,
    input  logic                i_usb_wr,
    input  logic                i_usb_pkt,
    input  logic [1:0]          iv_usb_addr,
    input  logic [U3_DATWD-1:0] iv_usb_data,
    input  logic                i_pc_busy,
    output logic                o_flaga,
    output logic                o_flagb,
    output logic                o_overflow,
    output logic [15:0]         ov_pkt_cnt
);

    localparam int unsigned BCNT_WD = $clog2(BUFFER_NUM + 1);
    localparam int unsigned DCNT_WD = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    localparam logic [BUF_DPTH_WD-1:0] WCNT_LAST  = BUF_DPTH_WD'(BUF_DPTH - 1);
    localparam logic [BUF_DPTH_WD-1:0] WCNT_WMARK = BUF_DPTH_WD'(BUF_DPTH - WMARK);
    localparam logic [BUF_DPTH_WD-1:0] WCNT_ONE   = BUF_DPTH_WD'(1);
    localparam logic [BCNT_WD-1:0]     BCNT_FULL  = BCNT_WD'(BUFFER_NUM);
    localparam logic [BCNT_WD-1:0]     BCNT_ONE   = BCNT_WD'(1);
    localparam logic [DCNT_WD-1:0]     DCNT_LAST  = DCNT_WD'(DRAIN_CYC - 1);
    localparam logic [DCNT_WD-1:0]     DCNT_ONE   = DCNT_WD'(1);
    // A pktend keeps the partial flag asserted for this many cycles.
    localparam logic [2:0]             PKT_HOLD   = 3'd4;

    logic              addr_valid;
    logic [CH_NUM-1:0] ch_full;
    logic [CH_NUM-1:0] ch_wmark;
    logic [CH_NUM-1:0] ch_pkt_recent;
    logic [CH_NUM-1:0] ch_commit;
    logic [CH_NUM-1:0] ch_drop;

    logic              sel_full;
    logic              sel_wmark;
    logic              sel_recent;
    logic              flagb_raw;
    logic [FLAG_DLY-1:0] flagb_q;

    // Data bus only qualifies strobes; fold it so it is visibly consumed.
    logic unused_data;
    assign unused_data = ^iv_usb_data;

    // Addresses at or beyond CH_NUM select no channel at all.
    assign addr_valid = (32'(iv_usb_addr) < CH_NUM);

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        logic [BUF_DPTH_WD-1:0] wcnt_q;
        logic [BCNT_WD-1:0]     bcnt_q;
        logic [DCNT_WD-1:0]     dcnt_q;
        logic [2:0]             pkt_hist_q;

        logic sel;
        logic wr_req;
        logic pkt_req;
        logic wr_acc;
        logic pkt_acc;
        logic auto_commit;
        logic commit;
        logic drain_run;
        logic drain_done;

        assign sel     = addr_valid && !i_usb_cs && (iv_usb_addr == 2'(c));
        assign wr_req  = sel && !i_usb_wr;
        assign pkt_req = sel && !i_usb_pkt;

        assign ch_full[c] = (bcnt_q == BCNT_FULL);
        assign wr_acc     = wr_req && !ch_full[c];
        assign pkt_acc    = pkt_req && !ch_full[c];

        // A write on the last word and a pktend together still yield one commit.
        assign auto_commit = wr_acc && (wcnt_q == WCNT_LAST);
        assign commit      = auto_commit || pkt_acc;

        assign drain_run  = !i_pc_busy && (bcnt_q != '0);
        assign drain_done = drain_run && (dcnt_q == DCNT_LAST);

        assign ch_commit[c]     = commit;
        assign ch_drop[c]       = (wr_req || pkt_req) && ch_full[c];
        assign ch_wmark[c]      = (wcnt_q >= WCNT_WMARK);
        assign ch_pkt_recent[c] = (pkt_hist_q != '0);

        // Word, committed-buffer, drain and pktend-history counters for this channel.
        always_ff @(posedge i_usb_pclk) begin
            if (!reset_n) begin
                wcnt_q     <= '0;
                bcnt_q     <= '0;
                dcnt_q     <= '0;
                pkt_hist_q <= '0;
            end else begin
                if (commit) begin
                    wcnt_q <= '0;
                end else if (wr_acc) begin
                    wcnt_q <= wcnt_q + WCNT_ONE;
                end

                // Simultaneous commit and drain cancel out.
                if (commit && !drain_done) begin
                    bcnt_q <= bcnt_q + BCNT_ONE;
                end else if (!commit && drain_done) begin
                    bcnt_q <= bcnt_q - BCNT_ONE;
                end

                if (drain_done) begin
                    dcnt_q <= '0;
                end else if (drain_run) begin
                    dcnt_q <= dcnt_q + DCNT_ONE;
                end

                if (pkt_req) begin
                    pkt_hist_q <= PKT_HOLD;
                end else if (pkt_hist_q != '0) begin
                    pkt_hist_q <= pkt_hist_q - 3'd1;
                end
            end
        end
    end

    // Route the addressed channel's status to the flag logic.
    always_comb begin
        sel_full   = 1'b0;
        sel_wmark  = 1'b0;
        sel_recent = 1'b0;
        for (int unsigned c = 0; c < CH_NUM; c++) begin
            if (iv_usb_addr == 2'(c)) begin
                sel_full   = ch_full[c];
                sel_wmark  = ch_wmark[c];
                sel_recent = ch_pkt_recent[c];
            end
        end
    end

    assign flagb_raw = !(sel_full || sel_wmark || sel_recent);
    assign o_flagb   = flagb_q[FLAG_DLY-1];

    // Registered flags, flagb delay line, sticky overflow and packet counter.
    always_ff @(posedge i_usb_pclk) begin
        if (!reset_n) begin
            o_flaga    <= 1'b1;
            flagb_q    <= '1;
            o_overflow <= 1'b0;
            ov_pkt_cnt <= 16'd0;
        end else begin
            o_flaga    <= !sel_full;
            flagb_q[0] <= flagb_raw;
            for (int unsigned i = 1; i < FLAG_DLY; i++) begin
                flagb_q[i] <= flagb_q[i-1];
            end
            if (|ch_drop) begin
                o_overflow <= 1'b1;
            end
            // Only the addressed channel can commit, so at most one per cycle.
            if (|ch_commit) begin
                ov_pkt_cnt <= ov_pkt_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/slave_fifo_mc.md
SLAVE_FIFO_MC -- requirements
Module: slave_fifo_mc

Interface
REQ-001 SHALL have parameter U3_DATWD, default 32, data bus width.
REQ-002 SHALL have parameter CH_NUM, default 4, number of sockets/channels (1..4).
REQ-003 SHALL have parameter BUF_DPTH_WD, default 13, width of per-buffer word counter.
REQ-004 SHALL have parameter BUF_DPTH, default 4096, words per buffer (<= 2^BUF_DPTH_WD - 1).
REQ-005 SHALL have parameter BUFFER_NUM, default 8, buffers per channel.
REQ-006 SHALL have parameter WMARK, default 6, partial-flag watermark in words.
REQ-007 SHALL have parameter FLAG_DLY, default 3, flagb pipeline depth in cycles (>=1).
REQ-008 SHALL have parameter DRAIN_CYC, default 16, host cycles to drain one committed buffer.
REQ-009 SHALL have port i_usb_pclk  input  1  sole clock; all logic on rising edge.
REQ-010 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-011 SHALL have port i_usb_cs  input  1  active-low chip select.
REQ-012 SHALL have port i_usb_wr  input  1  active-low write strobe.
REQ-013 SHALL have port i_usb_pkt  input  1  active-low packet end.
REQ-014 SHALL have port iv_usb_addr  input  2  channel select; values >= CH_NUM ignore writes/pktend.
REQ-015 SHALL have port iv_usb_data  input  U3_DATWD  write data (not stored; only counted).
REQ-016 SHALL have port i_pc_busy  input  1  high stalls host drain on all channels.
REQ-017 SHALL have port o_flaga  output  1  full flag of addressed channel, active-low.
REQ-018 SHALL have port o_flagb  output  1  partial/watermark flag of addressed channel, active-low.
REQ-019 SHALL have port o_overflow  output  1  sticky; write or pktend attempted while channel full.
REQ-020 SHALL have port ov_pkt_cnt  output  16  total committed packets/buffers, all channels, wraps.

Function
REQ-021 Per channel SHALL keep word count wcnt and committed-buffer count bcnt (0..BUFFER_NUM); both retained across address changes.
REQ-022 Write accepted when cs=0, wr=0, addr<CH_NUM, bcnt<BUFFER_NUM: wcnt+1; at wcnt reaching BUF_DPTH, wcnt->0 and bcnt+1 (auto-commit).
REQ-023 pktend (cs=0, pkt=0, addr valid, bcnt<BUFFER_NUM): commit current buffer, wcnt->0, bcnt+1; wcnt=0 commits zero-length packet.
REQ-024 Write and pktend in same cycle: word counted first, then one commit (never two).
REQ-025 Write or pktend when bcnt=BUFFER_NUM: dropped, counters unchanged, o_overflow->1 next cycle, held until reset.
REQ-026 Host drain: free-running drain counter per channel runs only when i_pc_busy=0 and bcnt>0; at DRAIN_CYC-1 bcnt-1, counter->0; busy freezes counter.
REQ-027 Commit and drain same cycle on same channel: bcnt unchanged.
REQ-028 o_flaga registered: 0 next cycle when addressed channel bcnt=BUFFER_NUM, else 1.
REQ-029 o_flagb raw = 0 when addressed channel bcnt=BUFFER_NUM, or wcnt >= BUF_DPTH-WMARK, or pktend seen in last 4 cycles; raw passes FLAG_DLY-stage shift register to o_flagb.
REQ-030 ov_pkt_cnt +1 per commit (auto or pktend), 16-bit wrap FFFF->0000.
REQ-031 Address change: flags reflect new channel per REQ-028/029 latency; no counter cleared.

Reset
REQ-032 reset_n=0 sampled at clock edge SHALL set all wcnt/bcnt/drain counters 0, o_flaga=1, all flagb stages and o_flagb=1, o_overflow=0, ov_pkt_cnt=0; mid-operation reset discards all buffered state.

Verification (CH_NUM=2, BUF_DPTH=16, BUFFER_NUM=2, WMARK=4, FLAG_DLY=3, DRAIN_CYC=8)
REQ-033 Busy=1, addr 0, 12 writes -> o_flagb low 4 cycles after 12th write (raw low one cycle after it), o_flaga=1.
REQ-034 Busy=1, 32 writes addr 0 -> bcnt=2, o_flaga=0 cycle after 32nd, 33rd write sets o_overflow=1, ov_pkt_cnt=2.
REQ-035 Fill ch0 full, switch addr to 1 -> o_flaga=1 next cycle; switch back -> 0; ch0 wcnt/bcnt intact.
REQ-036 Busy=1, 5 writes then pktend, then lone pktend -> ov_pkt_cnt=2 (second is ZLP), wcnt=0.
REQ-037 Ch0 full, release busy -> bcnt=1 after 8 cycles, o_flaga=1 next cycle; busy during drain delays by busy-cycle count.
REQ-038 Reset asserted mid-burst -> next-edge outputs per REQ-032, subsequent writes counted from 0.
